mult_div_unit: RTL

- Multi-cycle integer multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-file read operands (rs, rt values) and runs MIPS MULT, MULTU, DIV and DIVU.
- Results go to private HI/LO registers, which later MFHI/MFLO instructions read.
- Iterative datapath: one bit per clock, with a start/busy/done handshake to the pipeline control.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_sign_fix.sv | 21 ++
 rtl/mult_div_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and nominal iterative latency.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  localparam int MULDIV_LATENCY = 33;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of the magnitude
// product, quotient and remainder before HI/LO write-back.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               neg_prod_i,
  input  logic [WIDTH-1:0]   quot_i,
  input  logic               neg_quot_i,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic               neg_rem_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   quot_o,
  output logic [WIDTH-1:0]   rem_o
);

  assign prod_o = neg_prod_i ? -prod_i : prod_i;
  assign quot_o = neg_quot_i ? -quot_i : quot_i;
  assign rem_o  = neg_rem_i  ? -rem_i  : rem_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with private HI/LO.
// MULDIV_FAST_MULT_EN: single-cycle combinational multiply.
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic                 sa_q, sa_d;
  logic                 sb_q, sb_d;
  logic                 bz_q, bz_d;
  logic [WIDTH-1:0]     araw_q, araw_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 sgn1, sgn2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       dsh;
  logic                 qbit;
  logic [WIDTH-1:0]     rem_new;
  logic [2*WIDTH-1:0]   fix_prod;
  logic [WIDTH-1:0]     fix_quot;
  logic [WIDTH-1:0]     fix_rem;
  logic                 fast_mult;
  logic [2*WIDTH-1:0]   fast_prod;

  // signed ops work on magnitudes; sign restored in FIX
  assign sgn1 = ~op[0] & data1[WIDTH-1];
  assign sgn2 = ~op[0] & data2[WIDTH-1];
  assign mag1 = sgn1 ? -data1 : data1;
  assign mag2 = sgn2 ? -data2 : data2;

  // multiply step: {acc_hi, multiplier} shifts right
  assign msum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (p_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // restoring divide step: {rem, dividend} shifts left
  assign dsh     = p_q[2*WIDTH-1:WIDTH-1];
  assign qbit    = (dsh >= {1'b0, opnd_q});
  assign rem_new = qbit ? (dsh[WIDTH-1:0] - opnd_q)
                        : dsh[WIDTH-1:0];

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext1, ext2;
  assign ext1 = {{WIDTH{sgn1}}, data1};
  assign ext2 = {{WIDTH{sgn2}}, data2};
  assign fast_mult = ~op[1];
  assign fast_prod = ext1 * ext2;
`else
  assign fast_mult = 1'b0;
  assign fast_prod = '0;
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
    .prod_i     (p_q),
    .neg_prod_i (sa_q ^ sb_q),
    .quot_i     (p_q[WIDTH-1:0]),
    .neg_quot_i (sa_q ^ sb_q),
    .rem_i      (p_q[2*WIDTH-1:WIDTH]),
    .neg_rem_i  (sa_q),
    .prod_o     (fix_prod),
    .quot_o     (fix_quot),
    .rem_o      (fix_rem)
  );

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    araw_d  = araw_q;
    opnd_d  = opnd_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && fast_mult) begin
          {hi_d, lo_d} = fast_prod;
          done_d = 1'b1;
          dz_d   = 1'b0;
        end else if (start) begin
          op_d    = op;
          sa_d    = sgn1;
          sb_d    = sgn2;
          bz_d    = (data2 == '0);
          araw_d  = data1;
          cnt_d   = '0;
          opnd_d  = op[1] ? mag2 : mag1;
          p_d     = {{WIDTH{1'b0}},
                     (op[1] ? mag1 : mag2)};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (op_q[1])
          p_d = {rem_new, p_q[WIDTH-2:0], qbit};
        else
          p_d = {msum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1))
          state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          if (bz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = fix_rem;
            lo_d = fix_quot;
          end
          dz_d = bz_q;
        end else begin
          {hi_d, lo_d} = fix_prod;
          dz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      araw_q  <= '0;
      opnd_q  <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      araw_q  <= araw_d;
      opnd_q  <= opnd_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign divZero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
